fsk_deframer: RTL and testbench

FSK_DEFRAMER -- requirements
Module: fsk_deframer

---
 rtl/fsk_pkg.sv | 10 +
 rtl/crc16_serial.sv | 17 +
 rtl/fsk_deframer.sv | 115 +++++++++++
 tb/tb_fsk_deframer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// fsk_pkg: shared state encoding, CRC constants and default sync word for the FSK deframer
package fsk_pkg;
  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CRC} state_t;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] SYNC_DEFAULT = 16'hD391;
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/crc16_serial.sv
// crc16_serial: one-bit-per-cycle CRC-16-CCITT LFSR
module crc16_serial
  import fsk_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc
);
  // init wins over a bit so a fresh frame always starts from CRC_INIT
  always_ff @(posedge clk)
    if (rst) crc <= '0;
    else if (init) crc <= CRC_INIT;
    else if (bit_en) crc <= crc16_step(crc, bit_in);
endmodule

// File: rtl/fsk_deframer.sv
// fsk_deframer: sync hunt, length/payload extraction and CRC check of FSK bit frames
module fsk_deframer
  import fsk_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_DEFAULT,
  parameter int          MAX_LEN   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       pkt_start,
  output logic [7:0] pkt_len,
  output logic       pkt_done,
  output logic       crc_ok,
  output logic       len_err,
  output logic       busy
);
  localparam int BW = $clog2(MAX_LEN + 1);
  state_t state, state_d;
  logic [15:0] sr, crc_rx, crc;
  logic [7:0] byte_sr;
  logic [2:0] bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic take, crc_init, crc_en, start_d, dv_d, done_d, len_err_d;
  logic [15:0] sr_nxt, crc_rx_nxt;
  logic [7:0] byte_nxt, cnt_nxt;
  assign take = en & bit_valid;
  assign sr_nxt = {sr[14:0], bit_in};
  assign crc_rx_nxt = {crc_rx[14:0], bit_in};
  assign byte_nxt = {byte_sr[6:0], bit_in};
  assign cnt_nxt = 8'(byte_cnt) + 8'd1;
  assign busy = state != S_HUNT;
  crc16_serial u_crc (
    .clk(clk),
    .rst(rst),
    .init(crc_init),
    .bit_en(crc_en),
    .bit_in(bit_in),
    .crc(crc)
  );
  // state register
  always_ff @(posedge clk)
    if (rst) state <= S_HUNT;
    else state <= state_d;
  // next state and per-bit strobes; everything advances only on a consumed bit
  always_comb begin
    state_d = state;
    crc_init = 1'b0;
    crc_en = 1'b0;
    start_d = 1'b0;
    dv_d = 1'b0;
    done_d = 1'b0;
    len_err_d = 1'b0;
    if (take)
      case (state)
        S_HUNT:
          if (sr_nxt == SYNC_WORD) begin
            state_d = S_LEN;
            crc_init = 1'b1;
            start_d = 1'b1;
          end
        S_LEN: begin
          crc_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            len_err_d = int'({24'd0, byte_nxt}) > MAX_LEN;
            state_d = len_err_d ? S_HUNT : (byte_nxt == 8'd0 ? S_CRC : S_PAYLOAD);
          end
        end
        S_PAYLOAD: begin
          crc_en = 1'b1;
          dv_d = bit_cnt == 3'd7;
          state_d = (dv_d && cnt_nxt == pkt_len) ? S_CRC : S_PAYLOAD;
        end
        default: begin
          done_d = {byte_cnt[0], bit_cnt} == 4'hF;
          state_d = done_d ? S_HUNT : S_CRC;
        end
      endcase
  end
  // datapath: shifters, counters and registered output pulses
  always_ff @(posedge clk)
    if (rst) begin
      sr <= '0;
      crc_rx <= '0;
      byte_sr <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      data_out <= '0;
      pkt_len <= '0;
      data_valid <= 1'b0;
      pkt_start <= 1'b0;
      pkt_done <= 1'b0;
      crc_ok <= 1'b0;
      len_err <= 1'b0;
    end else begin
      data_valid <= dv_d;
      pkt_start <= start_d;
      pkt_done <= done_d;
      len_err <= len_err_d;
      crc_ok <= done_d && crc_rx_nxt == crc;
      if (take) begin
        sr <= (state == S_HUNT && state_d == S_HUNT) ? sr_nxt : '0;
        crc_rx <= crc_rx_nxt;
        byte_sr <= byte_nxt;
        bit_cnt <= state == S_HUNT ? 3'd0 : bit_cnt + 3'd1;
        byte_cnt <= state_d != state ? '0 : (bit_cnt == 3'd7 ? byte_cnt + BW'(1) : byte_cnt);
        data_out <= dv_d ? byte_nxt : data_out;
        pkt_len <= (state == S_LEN && bit_cnt == 3'd7) ? byte_nxt : pkt_len;
      end
    end
endmodule

// File: tb/tb_fsk_deframer.sv
// tb_fsk_deframer: table-driven frame tests with a byte/CRC-result scoreboard
module tb_fsk_deframer;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic [7:0] data_out, pkt_len;
  logic data_valid, pkt_start, pkt_done, crc_ok, len_err, busy;
  always #5 clk = ~clk;
  fsk_deframer #(.SYNC_WORD(16'hD391), .MAX_LEN(64)) dut (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(data_out), .data_valid(data_valid), .pkt_start(pkt_start),
    .pkt_len(pkt_len), .pkt_done(pkt_done), .crc_ok(crc_ok), .len_err(len_err), .busy(busy)
  );
  typedef struct {
    logic [7:0] len;
    int np;
    logic [3:0][7:0] p;
    bit flip;
    bit gaps;
    bit ok;
    bit lerr;
  } vec_t;
  vec_t vecs[9];
  int tests = 0, fails = 0;
  int n_dv = 0, n_start = 0, n_done = 0, n_lerr = 0;
  logic [7:0] exp_q[$];
  bit exp_ok_q[$];
  bit gaps = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r = c;
    for (int i = 7; i >= 0; i--) r = (r[15] ^ b[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction
  // scoreboard: every output pulse is matched against what the stimulus queued
  always @(negedge clk)
    if (!rst) begin
      if (pkt_start) n_start++;
      if (len_err) n_lerr++;
      if (data_valid) begin
        n_dv++;
        if (exp_q.size() == 0) check("unexpected_data_valid", 32'(data_out), 32'hFFFF_FFFF);
        else check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
      if (pkt_done) begin
        n_done++;
        if (exp_ok_q.size() == 0) check("unexpected_pkt_done", 32'(crc_ok), 32'hFFFF_FFFF);
        else check("crc_ok", 32'(crc_ok), 32'(exp_ok_q.pop_front()));
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      tick();
      en = 1'b1;
      bit_valid = 1'b0;
    end
  endtask
  task automatic send_bit(input logic b);
    if (gaps)
      repeat ($urandom_range(0, 3)) begin
        tick();
        en = 1'($urandom_range(0, 1));
        bit_valid = en ? 1'b0 : 1'($urandom_range(0, 1));
        bit_in = 1'($urandom_range(0, 1));
      end
    tick();
    en = 1'b1;
    bit_valid = 1'b1;
    bit_in = b;
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask
  function automatic logic [7:0] pay(input vec_t v, input int i);
    return v.np > 4 ? 8'(i * 37 + 5) : v.p[i];
  endfunction
  task automatic send_frame(input vec_t v);
    logic [15:0] c;
    logic [7:0] b;
    gaps = v.gaps;
    c = crc_upd(16'hFFFF, v.len);
    for (int i = 0; i < v.np; i++) c = crc_upd(c, pay(v, i));
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hD3); send_byte(8'h91);
    send_byte(v.len);
    if (!v.lerr) begin
      for (int i = 0; i < v.np; i++) begin
        b = pay(v, i) ^ ((v.flip && i == 1) ? 8'h04 : 8'h00);
        exp_q.push_back(b);
        send_byte(b);
      end
      exp_ok_q.push_back(v.ok);
      send_byte(c[15:8]);
      send_byte(c[7:0]);
    end
    idle(4);
    gaps = 0;
  endtask
  initial begin
    int s0, d0, v0, l0;
    vecs[0] = '{8'd3, 3, {8'h00, 8'h03, 8'h02, 8'h01}, 0, 0, 1, 0};
    vecs[1] = '{8'd3, 3, {8'h00, 8'h03, 8'h02, 8'h01}, 1, 0, 0, 0};
    vecs[2] = '{8'd65, 0, 32'h0, 0, 0, 0, 1};
    vecs[3] = '{8'd3, 3, {8'h00, 8'h03, 8'h02, 8'h01}, 0, 0, 1, 0};
    vecs[4] = '{8'd0, 0, 32'h0, 0, 0, 1, 0};
    vecs[5] = '{8'd4, 4, {8'h91, 8'hD3, 8'h91, 8'hD3}, 0, 0, 1, 0};
    vecs[6] = '{8'd4, 4, {8'h91, 8'hD3, 8'h91, 8'hD3}, 0, 1, 1, 0};
    vecs[7] = '{8'd3, 3, {8'h00, 8'h03, 8'h02, 8'h01}, 1, 1, 0, 0};
    vecs[8] = '{8'd64, 64, 32'h0, 0, 0, 1, 0};
    rst = 1'b1; en = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {data_out, pkt_len, data_valid, pkt_start, pkt_done, crc_ok, len_err, busy}, 32'h0);
    rst = 1'b0; bit_valid = 1'b0;
    idle(2);
    for (int k = 0; k < 9; k++) begin
      s0 = n_start; d0 = n_done; v0 = n_dv; l0 = n_lerr;
      send_frame(vecs[k]);
      check($sformatf("v%0d_pkt_start", k), 32'(n_start - s0), 32'd1);
      check($sformatf("v%0d_data_valid", k), 32'(n_dv - v0), vecs[k].lerr ? 32'd0 : 32'(vecs[k].np));
      check($sformatf("v%0d_pkt_done", k), 32'(n_done - d0), vecs[k].lerr ? 32'd0 : 32'd1);
      check($sformatf("v%0d_len_err", k), 32'(n_lerr - l0), 32'(vecs[k].lerr));
      check($sformatf("v%0d_pkt_len", k), 32'(pkt_len), 32'(vecs[k].len));
      check($sformatf("v%0d_busy", k), 32'(busy), 32'd0);
    end
    s0 = n_start; d0 = n_done;
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hD3); send_byte(8'h91);
    send_byte(8'd3);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    send_byte(8'h01); send_byte(8'h02);
    idle(2);
    check("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b1; en = 1'b1; bit_valid = 1'b1;
    tick(); tick();
    check("midreset_outputs", {data_out, pkt_len, data_valid, pkt_start, pkt_done, crc_ok, len_err, busy}, 32'h0);
    rst = 1'b0; bit_valid = 1'b0;
    idle(30);
    check("midreset_no_done", 32'(n_done - d0), 32'd0);
    check("midreset_bytes", 32'(exp_q.size()), 32'd0);
    d0 = n_done;
    send_frame(vecs[0]);
    check("post_reset_start", 32'(n_start - s0), 32'd2);
    check("post_reset_done", 32'(n_done - d0), 32'd1);
    check("post_reset_data_out_hold", 32'(data_out), 32'h03);
    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_exp_ok_empty", 32'(exp_ok_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
